// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared types and defaults for the cache line-transfer
// controller (state enum, address field widths, words per line).
package cache_mem_pkg;

  localparam int TAG_W      = 13;
  localparam int LINE_W     = 7;
  localparam int WORD_W     = 3;
  localparam int LINE_WORDS = 1 << WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    EV_ADDR,
    EV_LAT,
    EV_BUS,
    FL_BUS,
    FL_WR
  } state_e;

endpackage

// File: rtl/cache_mem_ctrl_seq.sv
// line_word_seq: word sequencer for one line transfer.
// Holds start word and n counter; idx = (start + n) mod line words.
// Ports: CLK, RESET (sync, active-high), load/start (begin a line),
//   inc (word done), idx / idx_next (current / following word),
//   last (current word is the final one of the line).
module line_word_seq
  import cache_mem_pkg::*;
#(
  parameter int WORD_W = cache_mem_pkg::WORD_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic [WORD_W-1:0] start,
  input  logic              inc,
  output logic [WORD_W-1:0] idx,
  output logic [WORD_W-1:0] idx_next,
  output logic              last
);

  localparam int NW = 1 << WORD_W;
  localparam logic [WORD_W:0] LAST_N = (WORD_W+1)'(NW - 1);

  logic [WORD_W-1:0] start_q, start_d;
  logic [WORD_W:0]   n_q, n_d;

  always_comb begin
    start_d = start_q;
    n_d     = n_q;
    if (load) begin
      start_d = start;
      n_d     = '0;
    end else if (inc) begin
      n_d = n_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_q <= '0;
      n_q     <= '0;
    end else begin
      start_q <= start_d;
      n_q     <= n_d;
    end
  end

  // Index wraps naturally in WORD_W bits.
  assign idx      = start_q + n_q[WORD_W-1:0];
  assign idx_next = idx + 1'b1;
  assign last     = (n_q == LAST_N);

endmodule

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: moves one 8-word line between the cache data RAM
// port B and the external word bus (eviction or fill).
// Ports: CLK, RESET (sync, active-high); cache side REQ_C2M, REQ_M2C,
//   NEW_TAG_A, OLD_TAG_A, LINE, WORD, DONE; RAM port B MEM_WE, MEM_A,
//   MEM_WD, MEM_RD; external bus EXT_REQ, EXT_WE, EXT_A, EXT_WD,
//   EXT_RD, EXT_ACK. All outputs registered.
// Build option: CACHE_MEM_CWF_EN makes fills critical-word-first.
module cache_mem_ctrl
  import cache_mem_pkg::*;
#(
  parameter int TAG_W  = cache_mem_pkg::TAG_W,
  parameter int LINE_W = cache_mem_pkg::LINE_W,
  parameter int WORD_W = cache_mem_pkg::WORD_W
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           REQ_C2M,
  input  logic                           REQ_M2C,
  input  logic [TAG_W-1:0]               NEW_TAG_A,
  input  logic [TAG_W-1:0]               OLD_TAG_A,
  input  logic [LINE_W-1:0]              LINE,
  input  logic [WORD_W-1:0]              WORD,
  output logic                           DONE,
  output logic                           MEM_WE,
  output logic [WORD_W-1:0]              MEM_A,
  output logic [31:0]                    MEM_WD,
  input  logic [31:0]                    MEM_RD,
  output logic                           EXT_REQ,
  output logic                           EXT_WE,
  output logic [TAG_W+LINE_W+WORD_W-1:0] EXT_A,
  output logic [31:0]                    EXT_WD,
  input  logic [31:0]                    EXT_RD,
  input  logic                           EXT_ACK
);

  localparam int AW = TAG_W + LINE_W + WORD_W;

  state_e            state_q, state_d;
  logic              prime_q, prime_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic              done_q, done_d;
  logic              ext_req_q, ext_req_d;
  logic              ext_we_q, ext_we_d;
  logic [AW-1:0]     ext_a_q, ext_a_d;
  logic [31:0]       ext_wd_q, ext_wd_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       mem_wd_q, mem_wd_d;

  logic              seq_load;
  logic              seq_inc;
  logic [WORD_W-1:0] seq_start;
  logic [WORD_W-1:0] idx;
  logic [WORD_W-1:0] idx_next;
  logic              last;
  logic [WORD_W-1:0] fill_start;

`ifdef CACHE_MEM_CWF_EN
  assign fill_start = WORD;
`else
  logic unused_word;
  assign fill_start  = '0;
  assign unused_word = ^WORD;
`endif

  line_word_seq #(
    .WORD_W (WORD_W)
  ) u_seq (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (seq_load),
    .start    (seq_start),
    .inc      (seq_inc),
    .idx      (idx),
    .idx_next (idx_next),
    .last     (last)
  );

  always_comb begin
    state_d   = state_q;
    prime_d   = 1'b0;
    tag_d     = tag_q;
    line_d    = line_q;
    done_d    = done_q;
    ext_req_d = ext_req_q;
    ext_we_d  = ext_we_q;
    ext_a_d   = ext_a_q;
    ext_wd_d  = ext_wd_q;
    mem_we_d  = 1'b0;
    mem_a_d   = mem_a_q;
    mem_wd_d  = mem_wd_q;
    seq_load  = 1'b0;
    seq_inc   = 1'b0;
    seq_start = '0;
    unique case (state_q)
      IDLE: begin
        if (REQ_C2M) begin
          state_d  = EV_ADDR;
          prime_d  = 1'b1;
          tag_d    = OLD_TAG_A;
          line_d   = LINE;
          done_d   = 1'b0;
          seq_load = 1'b1;
        end else if (REQ_M2C) begin
          state_d   = FL_BUS;
          prime_d   = 1'b1;
          tag_d     = NEW_TAG_A;
          line_d    = LINE;
          done_d    = 1'b0;
          seq_load  = 1'b1;
          seq_start = fill_start;
        end
      end
      // First cycle after leaving IDLE loads word-0 outputs
      // from the freshly latched request.
      EV_ADDR: begin
        if (prime_q) begin
          mem_a_d = idx;
        end else begin
          state_d = EV_LAT;
        end
      end
      EV_LAT: begin
        ext_wd_d  = MEM_RD;
        ext_req_d = 1'b1;
        ext_we_d  = 1'b1;
        ext_a_d   = {tag_q, line_q, idx};
        state_d   = EV_BUS;
      end
      EV_BUS: begin
        if (EXT_ACK) begin
          ext_req_d = 1'b0;
          ext_we_d  = 1'b0;
          seq_inc   = 1'b1;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = EV_ADDR;
            mem_a_d = idx_next;
          end
        end
      end
      FL_BUS: begin
        if (prime_q) begin
          ext_req_d = 1'b1;
          ext_we_d  = 1'b0;
          ext_a_d   = {tag_q, line_q, idx};
        end else if (EXT_ACK) begin
          ext_req_d = 1'b0;
          mem_wd_d  = EXT_RD;
          mem_we_d  = 1'b1;
          mem_a_d   = idx;
          state_d   = FL_WR;
        end
      end
      FL_WR: begin
        seq_inc = 1'b1;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          ext_req_d = 1'b1;
          ext_a_d   = {tag_q, line_q, idx_next};
          state_d   = FL_BUS;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      prime_q   <= 1'b0;
      tag_q     <= '0;
      line_q    <= '0;
      done_q    <= 1'b1;
      ext_req_q <= 1'b0;
      ext_we_q  <= 1'b0;
      ext_a_q   <= '0;
      ext_wd_q  <= '0;
      mem_we_q  <= 1'b0;
      mem_a_q   <= '0;
      mem_wd_q  <= '0;
    end else begin
      state_q   <= state_d;
      prime_q   <= prime_d;
      tag_q     <= tag_d;
      line_q    <= line_d;
      done_q    <= done_d;
      ext_req_q <= ext_req_d;
      ext_we_q  <= ext_we_d;
      ext_a_q   <= ext_a_d;
      ext_wd_q  <= ext_wd_d;
      mem_we_q  <= mem_we_d;
      mem_a_q   <= mem_a_d;
      mem_wd_q  <= mem_wd_d;
    end
  end

  assign DONE    = done_q;
  assign EXT_REQ = ext_req_q;
  assign EXT_WE  = ext_we_q;
  assign EXT_A   = ext_a_q;
  assign EXT_WD  = ext_wd_q;
  assign MEM_WE  = mem_we_q;
  assign MEM_A   = mem_a_q;
  assign MEM_WD  = mem_wd_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: line-level model of cache RAM, external memory
// and expected word transactions; randomized transfers and wait states.
module tb_cache_mem_ctrl;

  logic        CLK, RESET, REQ_C2M, REQ_M2C;
  logic [12:0] NEW_TAG_A, OLD_TAG_A;
  logic [6:0]  LINE;
  logic [2:0]  WORD;
  logic        DONE, MEM_WE, EXT_REQ, EXT_WE, EXT_ACK;
  logic [2:0]  MEM_A;
  logic [31:0] MEM_WD, MEM_RD, EXT_WD, EXT_RD;
  logic [22:0] EXT_A;

  cache_mem_ctrl dut (
    .CLK(CLK), .RESET(RESET), .REQ_C2M(REQ_C2M), .REQ_M2C(REQ_M2C),
    .NEW_TAG_A(NEW_TAG_A), .OLD_TAG_A(OLD_TAG_A), .LINE(LINE),
    .WORD(WORD), .DONE(DONE), .MEM_WE(MEM_WE), .MEM_A(MEM_A),
    .MEM_WD(MEM_WD), .MEM_RD(MEM_RD), .EXT_REQ(EXT_REQ),
    .EXT_WE(EXT_WE), .EXT_A(EXT_A), .EXT_WD(EXT_WD),
    .EXT_RD(EXT_RD), .EXT_ACK(EXT_ACK)
  );

`ifdef CACHE_MEM_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [22:0] a;
    logic [31:0] d;
  } xact_t;
  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
  } mwr_t;

  xact_t       xq[$];
  mwr_t        wq[$];
  logic [31:0] cram[8];
  logic [31:0] ext_mem[logic [22:0]];

  logic        pre_we;
  logic [2:0]  pre_a;
  logic [31:0] pre_d;

  int vec = 0, bad = 0;
  int busy, wait_sum, nwr, wcnt, wtgt, max_wait;
  bit held, ack_now, ack_prev, got_first;
  logic [22:0] h_a, last_a, first_a;
  logic [31:0] h_wd, last_wd;
  logic        h_we;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // Cache data RAM port B: synchronous read, one-cycle latency.
  always @(posedge CLK) begin
    if (pre_we) cram[pre_a] <= pre_d;
    else if (MEM_WE) cram[MEM_A] <= MEM_WD;
    MEM_RD <= cram[MEM_A];
  end

  function automatic logic [31:0] rdata(input logic [22:0] a);
    return {9'h15A, a} ^ {a[7:0], 24'h0};
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic flag(input string n);
    vec++;
    bad++;
    $display("FAIL %s: got event want none", n);
  endtask

  // External slave plus per-cycle compare against the expected queues.
  initial begin
    xact_t e;
    mwr_t  m;
    EXT_ACK = 0;
    EXT_RD  = 0;
    wcnt = 0; wtgt = 0; held = 0; ack_prev = 0;
    forever begin
      @(negedge CLK);
      ack_now = 0;
      EXT_ACK = 0;
      if (!EXT_REQ) wcnt = 0;
      else if (!RESET) begin
        if (wcnt >= wtgt) begin
          ack_now = 1;
          wait_sum += wcnt;
          wcnt = 0;
          wtgt = $urandom_range(0, max_wait);
        end else wcnt++;
      end
      if (ack_now) begin
        EXT_ACK = 1;
        if (EXT_WE) ext_mem[EXT_A] = EXT_WD;
        else EXT_RD = rdata(EXT_A);
      end
      if (!DONE) busy++;
      if (EXT_REQ && held) begin
        chk("hold_a", EXT_A, h_a);
        chk("hold_we", EXT_WE, h_we);
        chk("hold_wd", EXT_WD, h_wd);
      end
      if (!EXT_REQ || ack_now) held = 0;
      else if (!held) begin
        held = 1; h_a = EXT_A; h_we = EXT_WE; h_wd = EXT_WD;
      end
      if (ack_now) begin
        if (xq.size() == 0) flag("ext_extra");
        else begin
          e = xq.pop_front();
          chk("ext_we", EXT_WE, e.we);
          chk("ext_a", EXT_A, e.a);
          if (e.we) chk("ext_wd", EXT_WD, e.d);
        end
        if (!got_first) begin first_a = EXT_A; got_first = 1; end
        last_a = EXT_A;
        last_wd = EXT_WD;
      end
      if (MEM_WE) begin
        chk("we_after_ack", ack_prev, 1);
        if (wq.size() == 0) flag("mem_extra");
        else begin
          m = wq.pop_front();
          chk("mem_a", MEM_A, m.a);
          chk("mem_wd", MEM_WD, m.d);
        end
        nwr++;
      end
      ack_prev = ack_now;
    end
  end

  task automatic preload(input logic [31:0] base, input bit rnd);
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      pre_we = 1;
      pre_a  = 3'(k);
      pre_d  = rnd ? $urandom : base + 32'(k);
    end
    @(posedge CLK); #1;
    pre_we = 0;
  endtask

  task automatic start_req(input bit ev, input bit fl,
                           input logic [12:0] ot, input logic [12:0] nt,
                           input logic [6:0] ln, input logic [2:0] wd);
    logic [2:0]  st, kk;
    logic [22:0] a;
    st = CWF ? wd : 3'd0;
    for (int j = 0; j < 8; j++) begin
      if (ev) begin
        kk = 3'(j);
        xq.push_back('{1'b1, {ot, ln, kk}, cram[kk]});
      end else begin
        kk = st + 3'(j);
        a  = {nt, ln, kk};
        xq.push_back('{1'b0, a, 32'h0});
        wq.push_back('{kk, rdata(a)});
      end
    end
    @(posedge CLK); #1;
    chk("done_idle", DONE, 1);
    busy = 0; wait_sum = 0; nwr = 0; got_first = 0;
    REQ_C2M = ev; REQ_M2C = fl;
    OLD_TAG_A = ot; NEW_TAG_A = nt; LINE = ln; WORD = wd;
    @(posedge CLK); #1;
    chk("done_fall", DONE, 0);
    REQ_C2M = 0; REQ_M2C = 0;
    OLD_TAG_A = 13'($urandom); NEW_TAG_A = 13'($urandom);
    LINE = 7'($urandom); WORD = 3'($urandom);
  endtask

  task automatic finish_xfer(input bit ev, input logic [12:0] tg,
                             input logic [6:0] ln);
    int t = 0;
    logic [22:0] a;
    while (!DONE && t < 3000) begin @(posedge CLK); #1; t++; end
    if (!DONE) flag("done_timeout");
    chk("busy_cycles", busy, 1 + 8 * (ev ? 3 : 2) + wait_sum);
    chk("ext_left", xq.size(), 0);
    chk("mem_left", wq.size(), 0);
    for (int k = 0; k < 8; k++) begin
      a = {tg, ln, 3'(k)};
      if (ev) chk("evict_data",
                  ext_mem.exists(a) ? ext_mem[a] : 32'hDEAD0000,
                  cram[k]);
      else chk("fill_data", cram[k], rdata(a));
    end
  endtask

  initial begin
    bit ev;
    logic [12:0] ot, nt;
    logic [6:0]  ln;
    int t;
    RESET = 1; REQ_C2M = 0; REQ_M2C = 0;
    NEW_TAG_A = 0; OLD_TAG_A = 0; LINE = 0; WORD = 0;
    pre_we = 0; pre_a = 0; pre_d = 0; max_wait = 0;
    busy = 0; wait_sum = 0; nwr = 0; got_first = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_done", DONE, 1);
    chk("rst_ext_req", EXT_REQ, 0);
    chk("rst_ext_we", EXT_WE, 0);
    chk("rst_mem_we", MEM_WE, 0);
    chk("rst_mem_a", MEM_A, 0);
    chk("rst_mem_wd", MEM_WD, 0);
    chk("rst_ext_a", EXT_A, 0);
    chk("rst_ext_wd", EXT_WD, 0);
    RESET = 0;

    // Clean zero-wait fill.
    start_req(0, 1, 13'h0, 13'h0123, 7'h05, 3'd0);
    finish_xfer(0, 13'h0123, 7'h05);
    chk("clean_busy", busy, 17);
    chk("clean_first_a", first_a, 23'h048C28);
    chk("clean_last_a", last_a, 23'h048C2F);

    // Dirty zero-wait eviction.
    preload(32'hA0, 0);
    start_req(1, 0, 13'h1FFF, 13'h0, 7'h7F, 3'd2);
    finish_xfer(1, 13'h1FFF, 7'h7F);
    chk("evict_busy", busy, 25);
    chk("evict_first_a", first_a, 23'h7FFFF8);
    chk("evict_last_a", last_a, 23'h7FFFFF);
    chk("evict_last_wd", last_wd, 32'hA7);

    // Critical word first (word 6 leads only with the option built in).
    max_wait = 3;
    start_req(0, 1, 13'h0, 13'h0ABC, 7'h33, 3'd6);
    finish_xfer(0, 13'h0ABC, 7'h33);
    chk("cwf_first", first_a[2:0], CWF ? 3'd6 : 3'd0);

    // Both requests together: eviction wins with the old tag.
    preload(32'h0, 1);
    start_req(1, 1, 13'h0F0F, 13'h1111, 7'h12, 3'd4);
    finish_xfer(1, 13'h0F0F, 7'h12);
    chk("both_tag", first_a[22:10], 13'h0F0F);

    // Reset after the third fill word.
    max_wait = 2;
    start_req(0, 1, 13'h0, 13'h0777, 7'h40, 3'd0);
    t = 0;
    while (nwr < 3 && t < 500) begin @(posedge CLK); #1; t++; end
    if (nwr < 3) flag("rst_wait_timeout");
    RESET = 1;
    xq.delete();
    wq.delete();
    @(posedge CLK); #1;
    chk("midrst_done", DONE, 1);
    chk("midrst_ext_req", EXT_REQ, 0);
    chk("midrst_mem_we", MEM_WE, 0);
    RESET = 0;
    start_req(0, 1, 13'h0, 13'h0777, 7'h40, 3'd0);
    finish_xfer(0, 13'h0777, 7'h40);
    chk("restart_first", first_a, {13'h0777, 7'h40, 3'd0});

    // Randomized transfers with 0..10 cycle ACK waits.
    max_wait = 10;
    for (int r = 0; r < 14; r++) begin
      ev = 1'($urandom);
      ot = 13'($urandom);
      nt = 13'($urandom);
      ln = 7'($urandom);
      if (ev) preload(32'h0, 1);
      start_req(ev, !ev, ot, nt, ln, 3'($urandom));
      finish_xfer(ev, ev ? ot : nt, ln);
    end

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
